// File: rtl/sha256_block_padder_if.sv
// Stream bundle around the SHA-256 padder: message words in, padded block words out.
// The slave modport is the padder's own view; master is the driving environment.
interface sha256_block_padder_if;
   // Handshake: a word moves on a rising edge where valid && ready. Valid and its
   // payload hold until that edge, and ready never depends on valid.
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_blk_end;
   logic        out_msg_end;
   logic [2:0]  dbg_state;

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_blk_end,
      output out_msg_end,
      output dbg_state
   );

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_blk_end,
      input  out_msg_end,
      input  dbg_state
   );
endinterface

// File: rtl/sha256_block_padder.sv
// Streaming SHA-256 padder: forwards message words, then the 0x80000000 pad word,
// zero fill and the 64-bit bit length, through one registered output stage.
module sha256_block_padder #(
   parameter int CNT_W = 32
) (
   input logic                  clk,
   input logic                  reset,
   sha256_block_padder_if.slave bus
);

   typedef enum logic [2:0] {
      DATA   = 3'd0,
      PAD    = 3'd1,
      ZERO   = 3'd2,
      LEN_HI = 3'd3,
      LEN_LO = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [3:0]         pos_q, pos_d;
   logic [CNT_W-1:0]   nwords_q, nwords_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        out_data_q, out_data_d;
   logic               blk_end_q, blk_end_d;
   logic               msg_end_q, msg_end_d;

   logic               reg_free;
   logic               in_ready_c;
   logic               load;
   logic               load_last;
   logic [31:0]        load_data;
   logic [63:0]        bit_len;

   assign reg_free = !out_valid_q || bus.out_ready;
   assign bit_len  = 64'(nwords_q) << 5;

   always_comb begin
      state_d     = state_q;
      pos_d       = pos_q;
      nwords_d    = nwords_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      blk_end_d   = blk_end_q;
      msg_end_d   = msg_end_q;
      in_ready_c  = 1'b0;
      load        = 1'b0;
      load_last   = 1'b0;
      load_data   = 32'h0000_0000;

      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         DATA: begin
            in_ready_c = reg_free && !reset;
            if (bus.in_valid && in_ready_c) begin
               load      = 1'b1;
               load_data = bus.in_data;
               nwords_d  = nwords_q + CNT_W'(1);
               if (bus.in_last) begin
                  state_d = PAD;
               end
            end
         end

         PAD: begin
            if (reg_free) begin
               load      = 1'b1;
               load_data = 32'h8000_0000;
               // Jumping straight to the length words when the next slot is 14
               // keeps the stream free of an idle cycle.
               state_d   = (pos_q == 4'd13) ? LEN_HI : ZERO;
            end
         end

         ZERO: begin
            if (pos_q == 4'd14) begin
               state_d = LEN_HI;
            end else if (reg_free) begin
               load      = 1'b1;
               load_data = 32'h0000_0000;
               state_d   = (pos_q == 4'd13) ? LEN_HI : ZERO;
            end
         end

         LEN_HI: begin
            if (reg_free) begin
               load      = 1'b1;
               load_data = bit_len[63:32];
               state_d   = LEN_LO;
            end
         end

         LEN_LO: begin
            if (reg_free) begin
               load      = 1'b1;
               load_last = 1'b1;
               load_data = bit_len[31:0];
               nwords_d  = '0;
               state_d   = DATA;
            end
         end

         default: begin
            state_d = DATA;
         end
      endcase

      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = load_data;
         blk_end_d   = (pos_q == 4'd15) || load_last;
         msg_end_d   = load_last;
         pos_d       = load_last ? 4'd0 : pos_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= DATA;
         pos_q       <= 4'd0;
         nwords_q    <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'h0000_0000;
         blk_end_q   <= 1'b0;
         msg_end_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pos_q       <= pos_d;
         nwords_q    <= nwords_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         blk_end_q   <= blk_end_d;
         msg_end_q   <= msg_end_d;
      end
   end

   assign bus.in_ready    = in_ready_c;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.out_blk_end = blk_end_q;
   assign bus.out_msg_end = msg_end_q;
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_sha256_block_padder.sv
// Bench for sha256_block_padder: a reference padding model fills an expected
// queue per message and a negedge monitor pops and compares every output transfer.
module tb_sha256_block_padder;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sha256_block_padder_if bus ();

   sha256_block_padder #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [33:0] exp_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b1;
   bit          bp_en = 1'b0;
   int          cyc = 0;
   int          first_xfer = -1;
   int          last_xfer = -1;
   int          xfer_cnt = 0;
   logic        stall_prev = 1'b0;
   logic [31:0] data_prev = 32'h0;

   // out_ready driver: held high, or 50% random when backpressure is enabled
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: inputs only change 1 time unit after posedge, so negedge values
   // are what the next rising edge will see.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (stall_prev) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== data_prev) begin
               n_fail++;
               $display("FAIL hold_stable: out_valid=%b out_data=%h, required valid=1 data=%h",
                        bus.out_valid, bus.out_data, data_prev);
            end
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
            n_cmp++;
            if (bus.in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL in_ready_full: in_ready=%b, required 0", bus.in_ready);
            end
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && chk_en) begin
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
            xfer_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_out: data=%h blk=%b msg=%b, required no output",
                        bus.out_data, bus.out_blk_end, bus.out_msg_end);
            end else begin
               logic [33:0] exp_w;
               logic [33:0] got_w;
               exp_w = exp_q.pop_front();
               got_w = {bus.out_msg_end, bus.out_blk_end, bus.out_data};
               if (got_w !== exp_w) begin
                  n_fail++;
                  $display("FAIL out_word: got msg=%b blk=%b data=%h, required msg=%b blk=%b data=%h",
                           got_w[33], got_w[32], got_w[31:0], exp_w[33], exp_w[32], exp_w[31:0]);
               end
            end
         end
         stall_prev = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
         data_prev  = bus.out_data;
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Reference padding: data, pad word, zeros, then the 64-bit length in the last two slots
   task automatic push_expected(input int n, input logic [31:0] base);
      int          total;
      logic [63:0] len;
      logic [31:0] w;
      total = ((n + 3 + 15) / 16) * 16;
      len   = 64'(n) * 64'd32;
      for (int i = 0; i < total; i++) begin
         if (i < n)               w = base + 32'(i);
         else if (i == n)         w = 32'h8000_0000;
         else if (i == total - 2) w = len[63:32];
         else if (i == total - 1) w = len[31:0];
         else                     w = 32'h0;
         exp_q.push_back({(i == total - 1), ((i % 16) == 15), w});
      end
   endtask

   // Sends n words base, base+1, ...; in_valid stays high afterwards
   task automatic send_msg(input int n, input logic [31:0] base, input bit last_on_end, input bit push);
      int t;
      if (push) push_expected(n, base);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = base + 32'(i);
         bus.in_last  = last_on_end && (i == n - 1);
         t = 0;
         @(negedge clk);
         while (bus.in_ready !== 1'b1) begin
            @(negedge clk);
            t++;
            if (t > 1000) begin
               n_cmp++;
               n_fail++;
               $display("FAIL accept_timeout: word %0d not accepted, in_ready=%b required 1", i, bus.in_ready);
               return;
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input string name);
      int t;
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      bus.in_last  = 1'($urandom_range(0, 1));
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d words still expected, required 0", name, exp_q.size());
         exp_q.delete();
      end
      n_cmp++;
      if (bus.dbg_state !== 3'd0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_idle: state=%0d out_valid=%b, required state=0 valid=0",
                  name, bus.dbg_state, bus.out_valid);
      end
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 32'h0;
      bus.in_last  = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: %b, required 0", bus.out_valid); end
      n_cmp++;
      if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: %h, required 0", bus.out_data); end
      n_cmp++;
      if (bus.out_blk_end !== 1'b0 || bus.out_msg_end !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ends: blk=%b msg=%b, required 0 0", bus.out_blk_end, bus.out_msg_end);
      end
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: %b, required 0", bus.in_ready); end
      n_cmp++;
      if (bus.dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_state: %0d, required 0", bus.dbg_state); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: %b, required 1", bus.in_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_twenty_words();
      send_msg(20, 32'h0000_0000, 1'b1, 1'b1);
      wait_drain("twenty");
   endtask

   task automatic test_one_word();
      send_msg(1, 32'hDEAD_BEEF, 1'b1, 1'b1);
      wait_drain("one_word");
   endtask

   task automatic test_boundaries();
      send_msg(13, 32'hA500_0000, 1'b1, 1'b1);
      wait_drain("len13");
      send_msg(14, 32'hA600_0000, 1'b1, 1'b1);
      wait_drain("len14");
      send_msg(15, 32'hA700_0000, 1'b1, 1'b1);
      wait_drain("len15");
      send_msg(16, 32'hA800_0000, 1'b1, 1'b1);
      wait_drain("len16");
   endtask

   task automatic test_backpressure();
      bp_en = 1'b1;
      send_msg(20, 32'h0000_0000, 1'b1, 1'b1);
      wait_drain("backpressure");
      bp_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      chk_en = 1'b0;
      send_msg(7, 32'h5500_0000, 1'b0, 1'b0);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.dbg_state !== 3'd0) begin
         n_fail++;
         $display("FAIL mid_reset: out_valid=%b state=%0d, required 0 0", bus.out_valid, bus.dbg_state);
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      chk_en = 1'b1;
      send_msg(1, 32'h1234_5678, 1'b1, 1'b1);
      wait_drain("reset_mid");
   endtask

   task automatic test_back_to_back();
      first_xfer = -1;
      last_xfer  = -1;
      xfer_cnt   = 0;
      send_msg(1, 32'hCAFE_0000, 1'b1, 1'b1);
      send_msg(20, 32'h0100_0000, 1'b1, 1'b1);
      wait_drain("back_to_back");
      n_cmp++;
      if (xfer_cnt != 48) begin
         n_fail++;
         $display("FAIL b2b_count: %0d outputs, required 48", xfer_cnt);
      end
      n_cmp++;
      if (last_xfer - first_xfer != 47) begin
         n_fail++;
         $display("FAIL b2b_contiguous: span %0d cycles, required 47", last_xfer - first_xfer);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_twenty_words();
      test_one_word();
      test_boundaries();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
